// File: rtl/pipe_stage_reg_pkg.sv
// Shared types for the inter-stage pipeline registers: occupancy encoding
// and the packed stage payloads whose $bits sizes the register WIDTH.
package pipe_stage_reg_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_occ_t;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [9:0] imm;
  } dec_ex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [4:0]  rd;
    logic        we;
    logic [1:0]  mem_op;
  } ex_mem_t;

  localparam int DEC_EX_W = $bits(dec_ex_t);
  localparam int EX_MEM_W = $bits(ex_mem_t);

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter for stage performance statistics; sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK) begin
    if (RST)
      count <= '0;
    else if (inc && (count != {W{1'b1}}))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: valid/ready payload hand-off with optional
// skid entry, flush-to-bubble, hazard freeze and stall/flush statistics.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int WIDTH = DEC_EX_W,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  input  logic             freeze,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  pipe_occ_t        r_occ;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_skid;
  logic             r_in_rdy;
  logic             w_accept;
  logic             w_emit;

  assign out_valid = !freeze && (r_occ != EMPTY);
  assign out_data  = r_head;
  assign occ       = r_occ;
  assign w_accept  = in_valid && in_ready;
  assign w_emit    = out_valid && out_ready;

  // With a skid entry, ready comes from a flop so out_ready never reaches in_ready.
  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = !freeze && r_in_rdy;
    end else begin : g_noskid
      assign in_ready = !freeze && ((r_occ == EMPTY) || out_ready);
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_occ    <= EMPTY;
      r_head   <= '0;
      r_skid   <= '0;
      r_in_rdy <= 1'b0;
    end else if (flush) begin
      r_occ    <= EMPTY;
      r_head   <= '0;
      r_skid   <= '0;
      r_in_rdy <= 1'b1;
    end else begin
      r_in_rdy <= (r_occ != TWO);
      if (!freeze) begin
        case (r_occ)
          EMPTY: begin
            if (w_accept) begin
              r_occ  <= ONE;
              r_head <= in_data;
            end
          end
          ONE: begin
            if (w_accept && w_emit) begin
              r_head <= in_data;
            end else if (w_accept && (SKID != 0)) begin
              r_occ    <= TWO;
              r_skid   <= in_data;
              r_in_rdy <= 1'b0;
            end else if (w_emit) begin
              r_occ  <= EMPTY;
              r_head <= '0;
            end
          end
          TWO: begin
            if (w_emit) begin
              r_occ    <= ONE;
              r_head   <= r_skid;
              r_skid   <= '0;
              r_in_rdy <= 1'b1;
            end
          end
          default: r_occ <= EMPTY;
        endcase
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (out_valid && !out_ready),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (flush && (r_occ != EMPTY)),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: a SKID=1 stage for stream/backpressure/flush/freeze/reset
// and a SKID=0, CNT_W=2 stage for pass-through ready and counter saturation.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  int          total = 0;
  int          bad   = 0;

  logic        a_in_valid, a_in_ready, a_flush, a_freeze, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic [1:0]  a_occ;
  logic [15:0] a_stall, a_fcnt;

  logic        b_in_valid, b_in_ready, b_flush, b_freeze, b_out_valid, b_out_ready;
  logic [7:0]  b_in_data, b_out_data;
  logic [1:0]  b_occ;
  logic [1:0]  b_stall, b_fcnt;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(32), .SKID(1), .CNT_W(16)) u_a (
    .CLK(clk), .RST(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .flush(a_flush), .freeze(a_freeze),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .occ(a_occ), .stall_cnt(a_stall), .flush_cnt(a_fcnt)
  );

  pipe_stage_reg #(.WIDTH(8), .SKID(0), .CNT_W(2)) u_b (
    .CLK(clk), .RST(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .flush(b_flush), .freeze(b_freeze),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occ(b_occ), .stall_cnt(b_stall), .flush_cnt(b_fcnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 0; a_in_data = '0; a_flush = 0; a_freeze = 0; a_out_ready = 0;
    b_in_valid = 0; b_in_data = '0; b_flush = 0; b_freeze = 0; b_out_ready = 0;
    tick(); tick();

    chk("rst_a_in_ready",  a_in_ready, 0);
    chk("rst_a_out_valid", a_out_valid, 0);
    chk("rst_a_out_data",  a_out_data, 0);
    chk("rst_a_occ",       a_occ, 0);
    chk("rst_a_stall",     a_stall, 0);
    chk("rst_a_fcnt",      a_fcnt, 0);
    chk("rst_b_in_ready",  b_in_ready, 1);

    rst = 1'b0;
    tick();
    chk("rel_a_in_ready", a_in_ready, 1);

    // stream 1..8 with out_ready held high
    a_out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1; a_in_data = i;
      tick();
      chk("stream_data",  a_out_data, i);
      chk("stream_valid", a_out_valid, 1);
      chk("stream_occ",   a_occ, 1);
    end
    a_in_valid = 0;
    tick();
    chk("stream_drain_occ",  a_occ, 0);
    chk("stream_drain_data", a_out_data, 0);
    chk("stream_stall",      a_stall, 0);

    // backpressure
    a_out_ready = 0; a_in_valid = 1; a_in_data = 32'hA;
    tick();
    chk("bp_occ1", a_occ, 1);
    a_in_data = 32'hB;
    tick();
    chk("bp_occ2",      a_occ, 2);
    chk("bp_in_ready",  a_in_ready, 0);
    chk("bp_head",      a_out_data, 32'hA);
    a_in_data = 32'hC;
    tick(); tick(); tick();
    chk("bp_stall4",    a_stall, 4);
    chk("bp_hold_occ",  a_occ, 2);
    a_out_ready = 1;
    #1;
    chk("bp_rel_a", a_out_data, 32'hA);
    tick();
    chk("bp_rel_b",       a_out_data, 32'hB);
    chk("bp_rel_rdy",     a_in_ready, 1);
    tick();
    chk("bp_rel_c",       a_out_data, 32'hC);
    a_in_valid = 0;
    tick();
    chk("bp_empty",       a_occ, 0);
    chk("bp_stall_final", a_stall, 4);

    // flush with two entries and a colliding input
    a_out_ready = 0; a_in_valid = 1; a_in_data = 32'h11;
    tick();
    a_in_data = 32'h12;
    tick();
    chk("fl_pre_occ", a_occ, 2);
    a_flush = 1; a_in_data = 32'hD;
    tick();
    chk("fl_occ",   a_occ, 0);
    chk("fl_valid", a_out_valid, 0);
    chk("fl_data",  a_out_data, 0);
    chk("fl_cnt1",  a_fcnt, 1);
    chk("fl_stall", a_stall, 6);
    a_in_valid = 0;
    tick();
    chk("fl_empty_cnt", a_fcnt, 1);
    chk("fl_no_d",      a_occ, 0);
    a_flush = 0;

    // freeze and flush together: flush wins
    a_in_valid = 1; a_in_data = 32'h21;
    tick();
    chk("ff_pre_occ", a_occ, 1);
    a_in_valid = 0; a_freeze = 1; a_flush = 1;
    tick();
    chk("ff_occ", a_occ, 0);
    chk("ff_cnt", a_fcnt, 2);
    a_freeze = 0; a_flush = 0;

    // freeze alone holds contents for three cycles
    a_in_valid = 1; a_in_data = 32'h31;
    tick();
    a_freeze = 1; a_in_data = 32'h32; a_out_ready = 1;
    #1;
    chk("fz_in_ready",  a_in_ready, 0);
    chk("fz_out_valid", a_out_valid, 0);
    tick(); tick(); tick();
    chk("fz_occ",   a_occ, 1);
    chk("fz_data",  a_out_data, 32'h31);
    chk("fz_stall", a_stall, 6);
    a_freeze = 0; a_in_valid = 0;
    #1;
    chk("fz_rel_valid", a_out_valid, 1);
    tick();
    chk("fz_drain", a_occ, 0);

    // reset mid-operation
    a_out_ready = 0; a_in_valid = 1; a_in_data = 32'h41;
    tick();
    a_in_data = 32'h42;
    tick();
    chk("mr_occ",   a_occ, 2);
    chk("mr_stall", a_stall, 7);
    rst = 1;
    tick();
    chk("mr_in_ready",  a_in_ready, 0);
    chk("mr_out_valid", a_out_valid, 0);
    chk("mr_out_data",  a_out_data, 0);
    chk("mr_occ0",      a_occ, 0);
    chk("mr_stall0",    a_stall, 0);
    chk("mr_fcnt0",     a_fcnt, 0);
    rst = 0; a_in_data = 32'h51; a_out_ready = 1;
    tick();
    chk("mr_rel_rdy", a_in_ready, 1);
    chk("mr_rel_occ", a_occ, 0);
    tick();
    chk("mr_first_data", a_out_data, 32'h51);
    chk("mr_first_occ",  a_occ, 1);
    a_in_valid = 0;

    // SKID=0: combinational ready and saturation
    b_out_ready = 1; b_in_valid = 1; b_in_data = 8'h05;
    tick();
    chk("b_first", b_out_data, 8'h05);
    chk("b_rdy_comb", b_in_ready, 1);
    b_in_data = 8'h06;
    tick();
    chk("b_pass_data", b_out_data, 8'h06);
    chk("b_pass_occ",  b_occ, 1);
    b_out_ready = 0; b_in_data = 8'h07;
    #1;
    chk("b_rdy_drop", b_in_ready, 0);
    tick(); tick(); tick(); tick(); tick();
    chk("b_sat",      b_stall, 3);
    chk("b_hold",     b_out_data, 8'h06);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
